// File: rtl/des_round_key_schedule.sv
// DES round key schedule: takes the PC-1 halves C0/D0 and streams the 16 PC-2 subkeys.
// Decrypt order (K16..K1) is built only when DES_KS_DECRYPT_EN is defined.
module des_round_key_schedule #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [27:0] c_in,
    input  logic [27:0] d_in,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_num,
    output logic        busy,
    output logic        done
);

    // Buses are MSB-first: FIPS bit 1 sits in bit 27 of C/D and bit 47 of the subkey.
    localparam logic [3:0] LastRound = 4'(ROUNDS - 1);

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [47:0] subkey_q, subkey_d;
    logic [3:0]  round_q, round_d;
    logic        key_load;
    logic [55:0] cd_next;
    logic [47:0] key_next;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    // Encrypt rotation is 1 for rounds 1, 2, 9 and 16 (0-based 0, 1, 8, 15), else 2.
    function automatic logic enc_two(input logic [3:0] r);
        return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
    endfunction

`ifdef DES_KS_DECRYPT_EN
    logic mode_q, mode_d;

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Position 0 is emitted unrotated; positions 1, 8, 15 undo a 1-bit round.
    function automatic logic dec_two(input logic [3:0] p);
        return !(p == 4'd1 || p == 4'd8 || p == 4'd15);
    endfunction
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    assign cd_next = {c_d, d_d};

    for (genvar j = 0; j < 48; j++) begin : g_pc2
        assign key_next[47-j] = cd_next[56-PC2[j]];
    end

    assign subkey_d = key_load ? key_next : subkey_q;

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        round_d  = round_q;
        key_load = 1'b0;
`ifdef DES_KS_DECRYPT_EN
        mode_d   = mode_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
`ifdef DES_KS_DECRYPT_EN
                    mode_d = mode;
                    if (mode) begin
                        c_d = c_in;
                        d_d = d_in;
                    end else begin
                        c_d = rotl(c_in, 1'b0);
                        d_d = rotl(d_in, 1'b0);
                    end
`else
                    c_d = rotl(c_in, 1'b0);
                    d_d = rotl(d_in, 1'b0);
`endif
                    round_d  = '0;
                    key_load = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (subkey_ready) begin
                    if (round_q == LastRound) begin
                        state_d = StDone;
                    end else begin
                        round_d  = round_q + 4'd1;
                        key_load = 1'b1;
`ifdef DES_KS_DECRYPT_EN
                        if (mode_q) begin
                            c_d = rotr(c_q, dec_two(round_d));
                            d_d = rotr(d_q, dec_two(round_d));
                        end else begin
                            c_d = rotl(c_q, enc_two(round_d));
                            d_d = rotl(d_q, enc_two(round_d));
                        end
`else
                        c_d = rotl(c_q, enc_two(round_d));
                        d_d = rotl(d_q, enc_two(round_d));
`endif
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            c_q      <= '0;
            d_q      <= '0;
            subkey_q <= '0;
            round_q  <= '0;
`ifdef DES_KS_DECRYPT_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            subkey_q <= subkey_d;
            round_q  <= round_d;
`ifdef DES_KS_DECRYPT_EN
            mode_q   <= mode_d;
`endif
        end
    end

    assign subkey       = subkey_q;
    assign round_num    = round_q;
    assign subkey_valid = (state_q == StRun);
    assign busy         = (state_q == StRun) || (state_q == StDone);
    assign done         = (state_q == StDone);

endmodule

// File: tb/tb_des_round_key_schedule.sv
// Self-checking bench for des_round_key_schedule: known-answer table plus random streams
// checked against a cumulative-rotation reference model.
module tb_des_round_key_schedule;

    logic        clk = 1'b0;
    logic        reset, start, mode, subkey_ready;
    logic [27:0] c_in, d_in;
    logic [47:0] subkey;
    logic        subkey_valid, busy, done;
    logic [3:0]  round_num;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    des_round_key_schedule #(.ROUNDS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .c_in         (c_in),
        .d_in         (d_in),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_num    (round_num),
        .busy         (busy),
        .done         (done)
    );

    localparam logic [27:0] KC = 28'hF0CCAAF;
    localparam logic [27:0] KD = 28'h556678F;
    localparam logic [47:0] K1 = 48'h1B02EFFC7072;
    localparam logic [47:0] K2 = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct {
        logic [27:0] c;
        logic [27:0] d;
        logic        m;
        logic [3:0]  pos;
        logic [47:0] key;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [27:0] rotl_n(input logic [27:0] x, input int s);
        logic [27:0] r;
        r = (x << s) | (x >> (28 - s));
        return r;
    endfunction

    function automatic logic mode_eff(input logic m);
`ifdef DES_KS_DECRYPT_EN
        return m;
`else
        return 1'b0;
`endif
    endfunction

    // Subkey at emission position pos: K(pos+1) encrypting, K(16-pos) decrypting.
    function automatic logic [47:0] model_key(input logic [27:0] c0, input logic [27:0] d0,
                                              input logic m, input int pos);
        int rnd, total;
        logic [55:0] cd;
        logic [47:0] k;
        rnd = m ? 16 - pos : pos + 1;
        total = 0;
        for (int i = 0; i < rnd; i++) total += SHIFTS[i];
        cd = {rotl_n(c0, total % 28), rotl_n(d0, total % 28)};
        k = '0;
        for (int j = 0; j < 48; j++) k = (k << 1) | 48'((cd >> (56 - PC2[j])) & 56'd1);
        return k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input logic [27:0] c0, input logic [27:0] d0, input logic m,
                              input bit stall, input bit restart7);
        int n_acc, budget, stall_left;
        bit stall_done, held, injected;
        logic [47:0] held_k;
        logic [3:0] held_r;
        logic rdy;
        c_in = c0; d_in = d0; mode = m; start = 1'b1; subkey_ready = 1'b0;
        tick;
        start = 1'b0;
        check("first_valid", 64'(subkey_valid), 64'd1);
        check("first_round", 64'(round_num), 64'd0);
        n_acc = 0; budget = 300; stall_left = 5;
        stall_done = 0; held = 0; injected = 0;
        held_k = '0; held_r = '0;
        while (n_acc < 16 && budget > 0) begin
            budget--;
            start = 1'b0;
            if (held && subkey_valid) begin
                check("stall_key", 64'(subkey), 64'(held_k));
                check("stall_round", 64'(round_num), 64'(held_r));
            end
            if (restart7 && !injected && subkey_valid && round_num == 4'd7) begin
                injected = 1; start = 1'b1; mode = ~m;
                c_in = 28'($urandom); d_in = 28'($urandom);
            end
            if (!stall) rdy = 1'b1;
            else if (!stall_done) begin
                if (round_num == 4'd3 && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else begin
                    rdy = 1'b1;
                    if (stall_left == 0) stall_done = 1;
                end
            end else rdy = 1'($urandom_range(0, 1));
            subkey_ready = rdy;
            if (subkey_valid && rdy) begin
                check("round_num", 64'(round_num), 64'(n_acc));
                check("subkey", 64'(subkey), 64'(model_key(c0, d0, mode_eff(m), n_acc)));
                n_acc++;
                held = 0;
            end else held = subkey_valid;
            held_k = subkey;
            held_r = round_num;
            tick;
        end
        start = 1'b0;
        subkey_ready = 1'b0;
        check("accepts", 64'(n_acc), 64'd16);
        check("done_pulse", 64'({subkey_valid, busy, done}), 64'b011);
        if (!mode_eff(m)) begin
            check("final_c", 64'(dut.c_q), 64'(c0));
            check("final_d", 64'(dut.d_q), 64'(d0));
        end
        tick;
        check("done_clear", 64'({subkey_valid, busy, done}), 64'b000);
    endtask

    task automatic run_kat(input vec_t v);
        int budget;
        bit found;
        c_in = v.c; d_in = v.d; mode = v.m; start = 1'b1; subkey_ready = 1'b1;
        tick;
        start = 1'b0;
        found = 0;
        budget = 40;
        while (busy && budget > 0) begin
            budget--;
            if (subkey_valid && round_num == v.pos) begin
                check("kat_key", 64'(subkey), 64'(v.key));
                found = 1;
            end
            tick;
        end
        check("kat_found", 64'(found), 64'd1);
        subkey_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int budget;
        reset = 1'b1; start = 1'b0; mode = 1'b0; c_in = '0; d_in = '0; subkey_ready = 1'b0;
        tick;
        tick;
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_flags", 64'({subkey_valid, busy, done}), 64'b000);
        check("rst_round", 64'(round_num), 64'd0);
        reset = 1'b0;
        tick;

        vecs.push_back(vec_t'{c: KC, d: KD, m: 1'b0, pos: 4'd0, key: K1});
        vecs.push_back(vec_t'{c: KC, d: KD, m: 1'b0, pos: 4'd1, key: K2});
        vecs.push_back(vec_t'{c: KC, d: KD, m: 1'b0, pos: 4'd15, key: K16});
`ifdef DES_KS_DECRYPT_EN
        vecs.push_back(vec_t'{c: KC, d: KD, m: 1'b1, pos: 4'd0, key: K16});
        vecs.push_back(vec_t'{c: KC, d: KD, m: 1'b1, pos: 4'd15, key: K1});
`else
        vecs.push_back(vec_t'{c: KC, d: KD, m: 1'b1, pos: 4'd0, key: K1});
        vecs.push_back(vec_t'{c: KC, d: KD, m: 1'b1, pos: 4'd15, key: K16});
`endif
        foreach (vecs[i]) run_kat(vecs[i]);

        run_stream(KC, KD, 1'b0, 1'b0, 1'b0);
        run_stream(KC, KD, 1'b0, 1'b1, 1'b0);
        run_stream(KC, KD, 1'b0, 1'b0, 1'b1);
        run_stream(KC, KD, 1'b1, 1'b1, 1'b1);

        // Reset while mid-sequence abandons it.
        c_in = KC; d_in = KD; mode = 1'b0; start = 1'b1; subkey_ready = 1'b1;
        tick;
        start = 1'b0;
        budget = 40;
        while (!(subkey_valid && round_num == 4'd9) && budget > 0) begin
            budget--;
            tick;
        end
        check("reach_r9", 64'(round_num), 64'd9);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        subkey_ready = 1'b0;
        check("midrst_subkey", 64'(subkey), 64'd0);
        check("midrst_flags", 64'({subkey_valid, busy, done}), 64'b000);
        check("midrst_round", 64'(round_num), 64'd0);
        tick;
        check("midrst_idle", 64'({subkey_valid, busy}), 64'b00);
        run_stream(KC, KD, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_stream(28'($urandom), 28'($urandom), 1'(r), 1'(r >> 1), 1'(r == 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
